seq5_checker: RTL and testbench
===============================

# seq5_checker

Receive-side checker for the 3-bit five-state sequence source (5 at reset, then the cycle 0,1,2,4,6,0,...). It samples a 3-bit sequence bus and hunts for alignment. After a programmable run of correct transitions it declares lock. While locked it flags and counts every deviation. It sits at the consuming end of the sequence bus and gives lock/error status to the surrounding test and monitor logic.

## Interface
- LOCK_CNT, 3, consecutive correct transitions required to lock; legal range 1..15
- ERR_W, 8, width of the saturating error counter; minimum 1
- clk  in  1  clock, rising edge
- rstb  in  1  asynchronous active-low reset
- en  in  1  sample strobe; seq_in is evaluated only on cycles where en=1
- seq_in  in  3  observed sequence value
- locked  out  1  registered; 1 while the FSM is in LOCKED
- err  out  1  registered one-cycle pulse per mismatch detected in LOCKED
- err_count  out  ERR_W  number of errors since reset; saturates at all-ones
- expected  out  3  registered successor of the last accepted sample; 0 in HUNT

## Operation
- Successor function succ(x): 0->1, 1->2, 2->4, 4->6, 6->0, 5->6.
- Legal values are {0,1,2,4,5,6}. Values 3 and 7 are illegal. 5 is legal only as an entry value, because 5 is never a successor.
- Internal state: FSM (HUNT, SYNC, LOCKED), prev[2:0], match_cnt[3:0].
- HUNT, on en:
  - legal seq_in: prev<=seq_in, match_cnt<=0, go to SYNC.
  - illegal seq_in: stay in HUNT.
- SYNC, on en:
  - seq_in==succ(prev): prev<=seq_in, match_cnt++. When the incremented count equals LOCK_CNT, go to LOCKED.
  - else, legal seq_in: prev<=seq_in, match_cnt<=0, stay in SYNC.
  - else, illegal seq_in: go to HUNT.
  - No error is reported in SYNC.
- LOCKED, on en:
  - seq_in==succ(prev): prev<=seq_in, stay in LOCKED.
  - otherwise: err<=1, err_count increments with saturation.
    - legal seq_in: go to SYNC with prev<=seq_in, match_cnt<=0.
    - illegal seq_in: go to HUNT.
- en=0: FSM, prev, match_cnt, err_count and expected hold; err<=0.
- expected = succ(prev) in SYNC/LOCKED, 0 in HUNT. It is updated in the same edge as prev.
- err_count arithmetic is unsigned ERR_W bits. An increment at 2^ERR_W-1 leaves the value unchanged.

## Timing
- Reset values: locked=0, err=0, err_count=0, expected=0, FSM=HUNT, prev=0, match_cnt=0.
- Reset is asynchronous and takes effect immediately. Asserting it mid-lock drops locked and discards any pending err. The first en sample after deassertion is treated as a HUNT sample.
- All outputs are registered with 1-cycle latency:
  - locked rises on the edge that accepts the LOCK_CNT-th matching sample after the entry sample.
  - err and the err_count increment appear on the edge that accepts the mismatching sample.
  - locked falls on that same edge.
- err is high for exactly one cycle per mismatch. There is no second err until lock is reacquired.
- Back-to-back en is fully supported, with no throughput limit. Gaps in en are transparent, so the sequence is checked per sample, not per clock.
- With LOCK_CNT=1, a single correct transition after entry locks.

## Test plan
- Reset/idle: hold rstb=0, drive en=1 with random seq_in, then release with en=0 for 5 cycles -> locked=0, err=0, err_count=0, expected=0 throughout.
- Acquisition, LOCK_CNT=3: en=1, seq_in 5,6,0,1,2 on consecutive cycles.
  - Expected after each edge: 6,0,1,2,4.
  - locked=1 from the edge that samples 1; err never asserts.
- Illegal mismatch while locked: stream locked at prev=2, drive 3 instead of 4.
  - err=1 for one cycle, err_count=1, locked=0, expected=0 (HUNT).
  - Then 6,0,1,2 -> relock on the edge that samples 2.
- Legal mismatch while locked: at prev=2 drive 1.
  - err pulse, err_count+1, FSM=SYNC, expected=2.
  - Then 2,4,6 -> locked=1 on the edge that samples 6.
- en gating: locked at prev=4, drive en=0 with seq_in=7 for 4 cycles, then en=1 with seq_in=6 -> no err, locked stays 1, expected 6 then 0.
- Saturation, ERR_W=2, LOCK_CNT=1: force 5 lock/mismatch cycles -> err pulses 5 times, err_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/seq5_checker.sv
// -----------------------------------------------------------------------------
// seq5_checker
//
// Receive-side checker for the five-state sequence source. The source emits 5
// once after reset and then cycles 0,1,2,4,6,0,... This block samples the
// sequence bus on strobed cycles, hunts for alignment, declares lock after
// LOCK_CNT consecutive correct transitions, and, while locked, flags and counts
// every deviation.
//
// Parameters
//   LOCK_CNT  consecutive correct transitions needed to lock (1..15)
//   ERR_W     width of the saturating error counter (>= 1)
//
// Ports
//   clk        in   rising-edge clock
//   rstb       in   asynchronous active-low reset
//   en         in   sample strobe; seq_in is evaluated only when en=1
//   seq_in     in   observed 3-bit sequence value
//   locked     out  registered, 1 while the checker is in LOCKED
//   err        out  registered one-cycle pulse per mismatch seen in LOCKED
//   err_count  out  errors since reset, saturating at all-ones
//   expected   out  registered successor of the last accepted sample, 0 in HUNT
// -----------------------------------------------------------------------------
module seq5_checker #(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic [2:0]       seq_in,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       expected
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

  // Successor in the source sequence. 5 only appears as the post-reset entry
  // value and is followed by 6; 3 and 7 never occur in a valid stream.
  function automatic logic [2:0] succ(input logic [2:0] x);
    logic [2:0] s;
    case (x)
      3'd0:    s = 3'd1;
      3'd1:    s = 3'd2;
      3'd2:    s = 3'd4;
      3'd4:    s = 3'd6;
      3'd6:    s = 3'd0;
      3'd5:    s = 3'd6;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  function automatic logic is_legal(input logic [2:0] x);
    return (x != 3'd3) && (x != 3'd7);
  endfunction

  logic [1:0]       state_q,     state_d;
  logic [2:0]       prev_q,      prev_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic             locked_q,    locked_d;
  logic             err_q,       err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [2:0]       expected_q,  expected_d;

  logic       seq_match;
  logic       seq_legal;
  logic [3:0] match_cnt_inc;

  assign seq_match     = (seq_in == succ(prev_q));
  assign seq_legal     = is_legal(seq_in);
  assign match_cnt_inc = match_cnt_q + 4'd1;

  always_comb begin
    // NOTE: every variable gets a hold/default value before any branch so that
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    prev_d      = prev_q;
    match_cnt_d = match_cnt_q;
    err_count_d = err_count_q;
    err_d       = 1'b0;

    if (en) begin
      case (state_q)
        ST_HUNT: begin
          if (seq_legal) begin
            prev_d      = seq_in;
            match_cnt_d = 4'd0;
            state_d     = ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (seq_match) begin
            prev_d      = seq_in;
            match_cnt_d = match_cnt_inc;
            if (match_cnt_inc == LOCK_TARGET) state_d = ST_LOCKED;
          end else if (seq_legal) begin
            // Treat a legal but wrong value as a fresh entry point.
            prev_d      = seq_in;
            match_cnt_d = 4'd0;
          end else begin
            state_d = ST_HUNT;
          end
        end

        ST_LOCKED: begin
          if (seq_match) begin
            prev_d = seq_in;
          end else begin
            err_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
            if (seq_legal) begin
              prev_d      = seq_in;
              match_cnt_d = 4'd0;
              state_d     = ST_SYNC;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end

    // With en=0 both state and prev hold, so expected holds as well.
    expected_d = (state_d == ST_HUNT) ? 3'd0 : succ(prev_d);
    locked_d   = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rstb) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rstb) begin
      state_q     <= ST_HUNT;
      prev_q      <= 3'd0;
      match_cnt_q <= 4'd0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      expected_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_cnt_q <= match_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      expected_q  <= expected_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_seq5_checker.sv
// -----------------------------------------------------------------------------
// tb_seq5_checker
//
// Drives two checker instances from one stimulus stream: inst a with
// LOCK_CNT=3/ERR_W=8, inst b with LOCK_CNT=1/ERR_W=2 (for counter saturation).
// A behavioural model predicts each instance's outputs for every clock; the
// prediction is queued by the driver and compared by an independent monitor.
// -----------------------------------------------------------------------------
module tb_seq5_checker;

  logic       clk;
  logic       rstb;
  logic       en;
  logic [2:0] seq_in;

  logic       a_locked, a_err;
  logic [7:0] a_err_count;
  logic [2:0] a_expected;
  logic       b_locked, b_err;
  logic [1:0] b_err_count;
  logic [2:0] b_expected;

  seq5_checker #(.LOCK_CNT(3), .ERR_W(8)) dut_a (
    .clk(clk), .rstb(rstb), .en(en), .seq_in(seq_in),
    .locked(a_locked), .err(a_err), .err_count(a_err_count), .expected(a_expected)
  );

  seq5_checker #(.LOCK_CNT(1), .ERR_W(2)) dut_b (
    .clk(clk), .rstb(rstb), .en(en), .seq_in(seq_in),
    .locked(b_locked), .err(b_err), .err_count(b_err_count), .expected(b_expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // mode: 0 = hunting, 1 = syncing, 2 = locked
  typedef struct {
    int mode;
    int prev;
    int run;
    int errs;
    bit err;
  } mdl_t;

  typedef struct {
    logic        locked;
    logic        err;
    logic [31:0] cnt;
    logic [2:0]  exp;
  } obs_t;

  // Next value in the source stream; -1 for values that never occur.
  function automatic int m_succ(input int x);
    int cyc [5] = '{0, 1, 2, 4, 6};
    if (x == 5) return 6;
    for (int i = 0; i < 5; i++)
      if (cyc[i] == x) return cyc[(i + 1) % 5];
    return -1;
  endfunction

  function automatic mdl_t m_reset();
    mdl_t r;
    r.mode = 0; r.prev = 0; r.run = 0; r.errs = 0; r.err = 1'b0;
    return r;
  endfunction

  function automatic mdl_t m_step(input mdl_t m, input int lock_cnt, input int err_max,
                                  input bit e, input int x);
    mdl_t r = m;
    bit   legal = (m_succ(x) >= 0);
    r.err = 1'b0;
    if (!e) return r;
    if (m.mode == 0) begin
      if (legal) begin r.mode = 1; r.prev = x; r.run = 0; end
    end else if (x == m_succ(m.prev)) begin
      r.prev = x;
      if (m.mode == 1) begin
        r.run = m.run + 1;
        if (r.run == lock_cnt) r.mode = 2;
      end
    end else begin
      if (m.mode == 2) begin
        r.err = 1'b1;
        if (m.errs < err_max) r.errs = m.errs + 1;
      end
      if (legal) begin r.mode = 1; r.prev = x; r.run = 0; end
      else r.mode = 0;
    end
    return r;
  endfunction

  function automatic obs_t m_obs(input mdl_t m);
    obs_t o;
    o.locked = (m.mode == 2);
    o.err    = m.err;
    o.cnt    = 32'(m.errs);
    o.exp    = (m.mode == 0) ? 3'd0 : 3'(m_succ(m.prev));
    return o;
  endfunction

  mdl_t model_a, model_b;
  obs_t q_a[$];
  obs_t q_b[$];

  // ---------------------------------------------------------------- driver
  task automatic step(input bit e, input int x);
    @(negedge clk);
    rstb   = 1'b1;
    en     = e;
    seq_in = 3'(x);
    model_a = m_step(model_a, 3, 255, e, x);
    model_b = m_step(model_b, 1, 3, e, x);
    q_a.push_back(m_obs(model_a));
    q_b.push_back(m_obs(model_b));
  endtask

  // Reset asserted between edges with live random stimulus on the bus.
  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rstb   = 1'b0;
      en     = 1'b1;
      seq_in = 3'($urandom_range(0, 7));
      model_a = m_reset();
      model_b = m_reset();
      q_a.push_back(m_obs(model_a));
      q_b.push_back(m_obs(model_b));
    end
  endtask

  task automatic run_seq(input int vals[$]);
    foreach (vals[i]) step(1'b1, vals[i]);
  endtask

  // ---------------------------------------------------------------- monitor
  bit done = 1'b0;

  always @(posedge clk) begin
    obs_t e;
    #1;
    if (!done && q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a.locked",    32'(a_locked),    32'(e.locked));
      check("a.err",       32'(a_err),       32'(e.err));
      check("a.err_count", 32'(a_err_count), e.cnt);
      check("a.expected",  32'(a_expected),  32'(e.exp));
    end
    if (!done && q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b.locked",    32'(b_locked),    32'(e.locked));
      check("b.err",       32'(b_err),       32'(e.err));
      check("b.err_count", 32'(b_err_count), e.cnt);
      check("b.expected",  32'(b_expected),  32'(e.exp));
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rstb    = 1'b0;
    en      = 1'b0;
    seq_in  = 3'd0;
    model_a = m_reset();
    model_b = m_reset();

    // Reset with activity on the bus, then idle.
    do_reset(4);
    repeat (5) step(1'b0, $urandom_range(0, 7));

    // Acquisition from the post-reset entry value.
    run_seq('{5, 6, 0, 1, 2});
    // Illegal mismatch while locked, then relock.
    run_seq('{3, 6, 0, 1, 2});
    // Legal mismatch while locked, then relock.
    run_seq('{1, 2, 4, 6});
    // Strobe gating: held bus garbage must be ignored.
    run_seq('{0, 1, 2, 4});
    repeat (4) step(1'b0, 7);
    run_seq('{6, 0});
    // Reset in the middle of lock.
    do_reset(2);
    // Repeated lock/mismatch cycles drive inst b's counter into saturation.
    repeat (5) run_seq('{0, 1, 3});
    // Sequence starting at a legal non-entry value and SYNC re-entry on 5.
    run_seq('{4, 6, 5, 6, 0, 1, 2, 4, 6, 7, 7, 2});

    // Randomized traffic, mostly following the stream with sporadic faults.
    for (int n = 0; n < 2000; n++) begin
      int  r;
      int  x;
      bit  e;
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        e = ($urandom_range(0, 9) < 8);
        r = $urandom_range(0, 99);
        if (r < 80 && model_a.mode != 0) x = m_succ(model_a.prev);
        else if (r < 85)                  x = 5;
        else                              x = $urandom_range(0, 7);
        step(e, x);
      end
    end

    // Let the monitor drain the last predictions, with a bounded wait.
    for (int i = 0; i < 10 && (q_a.size() > 0 || q_b.size() > 0); i++) @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    check("drain.q_a", 32'(q_a.size()), 32'd0);
    check("drain.q_b", 32'(q_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
